// File: rtl/cdc_xfer_ctrl.sv
// Source-side controller for a 4-phase req/ack multi-bit crossing: round-robin
// arbitration among local requesters, held data bus and a 2-FF ack synchronizer.
module cdc_xfer_ctrl #(
  parameter  int N_REQ   = 4,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 255,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        in_valid,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  output logic [N_REQ-1:0]        in_ready,
  output logic                    xfer_req,
  output logic [DATA_W-1:0]       xfer_data,
  output logic [ID_W-1:0]         xfer_id,
  input  logic                    xfer_ack,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  input  logic                    err_clr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] T_LIM = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REL
  } state_t;

  state_t            state;
  logic              ack_m;
  logic              ack_s;
  logic [1:0]        sync_vld;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win;
  logic              found;
  logic              grant;
  logic [DATA_W-1:0] win_data;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              tmo_hit;

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // ack_s is only trusted once the synchronizer has refilled after reset, so a
  // stale ack still high from an interrupted transfer blocks the next grant.
  assign grant    = !rst && (state == IDLE) && sync_vld[1] && !ack_s && found;
  assign in_ready = grant ? (N_REQ'(1) << win) : '0;
  assign win_data = in_data[int'(win)*DATA_W +: DATA_W];
  assign done     = !rst && (state == REL) && !ack_s;
  assign busy     = (state != IDLE);

  // Wait counter holds the number of cycles spent in the current REQ/REL visit.
  always_comb begin
    cnt_nxt = '0;
    tmo_hit = 1'b0;
    if (grant || (state == REQ && ack_s)) begin
      cnt_nxt = CNT_W'(1);
      tmo_hit = (TIMEOUT == 1);
    end else if (state == REQ || (state == REL && ack_s)) begin
      cnt_nxt = (cnt == T_LIM) ? cnt : cnt + CNT_W'(1);
      tmo_hit = (TIMEOUT != 0) && (cnt != T_LIM) && (cnt_nxt == T_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ack_m       <= 1'b0;
      ack_s       <= 1'b0;
      sync_vld    <= 2'b00;
      rr_ptr      <= '0;
      cnt         <= '0;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      xfer_id     <= '0;
      timeout_err <= 1'b0;
    end else begin
      ack_m    <= xfer_ack;
      ack_s    <= ack_m;
      sync_vld <= {sync_vld[0], 1'b1};
      cnt      <= cnt_nxt;
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (grant) begin
            xfer_data <= win_data;
            xfer_id   <= win;
            rr_ptr    <= (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
            xfer_req  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            xfer_req <= 1'b0;
            state    <= REL;
          end
        end
        REL: begin
          if (!ack_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_xfer_ctrl.sv
// Directed and randomized bench for cdc_xfer_ctrl with an echoing destination
// model and a round-robin reference that predicts every grant.
module tb_cdc_xfer_ctrl;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int IW  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_ready;
  logic            xfer_req;
  logic [DW-1:0]   xfer_data;
  logic [IW-1:0]   xfer_id;
  logic            xfer_ack = 1'b0;
  logic            busy;
  logic            done;
  logic            timeout_err;
  logic            err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int grant_cnt = 0;
  int done_cnt = 0;
  int aborted = 0;
  int grant_log[$];
  int rr_model = 0;
  bit prev_grant = 0;
  logic [DW-1:0] exp_data = '0;
  int exp_id = 0;
  bit auto_ack = 1;
  int ack_dly = 3;
  int dcnt = 0;

  always #5 clk = ~clk;

  cdc_xfer_ctrl #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .xfer_req(xfer_req), .xfer_data(xfer_data),
    .xfer_id(xfer_id), .xfer_ack(xfer_ack), .busy(busy), .done(done),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*DW-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  function automatic int pickWinner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Destination side: echo xfer_req onto xfer_ack after ack_dly cycles.
  always begin
    @(negedge clk);
    if (auto_ack && (xfer_ack !== xfer_req)) begin
      if (dcnt >= ack_dly) begin
        xfer_ack = xfer_req;
        dcnt = 0;
      end else begin
        dcnt++;
      end
    end else begin
      dcnt = 0;
    end
  end

  // Monitor: predicts each grant from the round-robin rule and checks the held bus.
  always begin
    int ew;
    int aid;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (prev_grant) checkOutput("req_latency", xfer_req, 1);
      prev_grant = 0;
      if (in_ready != '0) begin
        ew = pickWinner(in_valid, rr_model);
        checkOutput("grant_onehot", in_ready, (ew < 0) ? 0 : (1 << ew));
        checkOutput("grant_only_idle", busy, 0);
        aid = 0;
        for (int i = 0; i < N; i++) if (in_ready[i]) aid = i;
        grant_log.push_back(aid);
        exp_data = in_data[aid*DW +: DW];
        exp_id = aid;
        if (ew >= 0) rr_model = (ew + 1) % N;
        grant_cnt++;
        prev_grant = 1;
      end else if (busy) begin
        checkOutput("data_stable", xfer_data, exp_data);
        checkOutput("id_stable", xfer_id, exp_id);
      end
      if (done) begin
        done_cnt++;
        checkOutput("done_while_busy", busy, 1);
      end
    end
  end

  task automatic waitGrant(input int target, input int budget, input string tag);
    for (int n = 0; n < budget; n++) begin
      #3;
      if (grant_cnt >= target) break;
      @(negedge clk);
    end
    checkOutput(tag, grant_cnt, target);
  endtask

  task automatic waitDone(input int target, input int budget, input string tag);
    for (int n = 0; n < budget; n++) begin
      #3;
      if (done_cnt >= target) break;
      @(negedge clk);
    end
    checkOutput(tag, done_cnt, target);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    rr_model = 0;
    prev_grant = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int g;
    int d;
    int base;
    logic [N*DW-1:0] words;

    // Reset state, with requests pending to show in_ready stays low.
    in_valid = 4'b1111;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_xfer_req", xfer_req, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_data", xfer_data, 0);
    checkOutput("rst_id", xfer_id, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = '0;

    $display("[TB] single transfer");
    @(negedge clk);
    words = {$urandom(), $urandom(), $urandom(), 32'hDEADBEEF};
    applyStimulus(4'b0001, words);
    waitGrant(1, 100, "single_grant");
    @(negedge clk);
    in_valid = '0;
    waitDone(1, 100, "single_done");
    @(negedge clk);
    #2;
    checkOutput("single_data", xfer_data, 32'hDEADBEEF);
    checkOutput("single_id", xfer_id, 0);
    checkOutput("single_idle", busy, 0);
    checkOutput("single_ready_cnt", grant_cnt, 1);
    checkOutput("single_done_cnt", done_cnt, 1);

    $display("[TB] fairness");
    applyReset();
    @(negedge clk);
    base = grant_log.size();
    g = grant_cnt + 8;
    d = done_cnt + 8;
    words = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(4'b1111, words);
    waitGrant(g, 600, "fair_grants");
    @(negedge clk);
    in_valid = '0;
    waitDone(d, 100, "fair_done");
    for (int i = 0; i < 8; i++) checkOutput("rr_order", grant_log[base+i], i % 4);

    $display("[TB] wrap and skip");
    @(negedge clk);
    g = grant_cnt + 1;
    d = done_cnt + 1;
    applyStimulus(4'b0100, {$urandom(), $urandom(), $urandom(), $urandom()});
    waitGrant(g, 100, "wrap_setup_grant");
    @(negedge clk);
    in_valid = '0;
    waitDone(d, 100, "wrap_setup_done");
    @(negedge clk);
    base = grant_log.size();
    g = grant_cnt + 2;
    d = done_cnt + 2;
    applyStimulus(4'b0101, {$urandom(), $urandom(), $urandom(), $urandom()});
    waitGrant(g, 200, "wrap_grants");
    @(negedge clk);
    in_valid = '0;
    waitDone(d, 100, "wrap_done");
    checkOutput("wrap_first", grant_log[base], 0);
    checkOutput("wrap_second", grant_log[base+1], 2);

    $display("[TB] timeout");
    @(negedge clk);
    auto_ack = 0;
    xfer_ack = 1'b0;
    g = grant_cnt + 1;
    applyStimulus(4'b0010, {$urandom(), $urandom(), $urandom(), $urandom()});
    waitGrant(g, 100, "tmo_grant");
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = '0;
      #2;
      checkOutput("tmo_req_held", xfer_req, 1);
      if (k == 1 || k == 15) checkOutput("tmo_early", timeout_err, 0);
      if (k >= 16) checkOutput("tmo_set", timeout_err, 1);
    end
    @(negedge clk);
    d = done_cnt + 1;
    ack_dly = 0;
    auto_ack = 1;
    waitDone(d, 100, "tmo_done");
    @(negedge clk);
    #2;
    checkOutput("tmo_sticky", timeout_err, 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #2;
    checkOutput("tmo_cleared", timeout_err, 0);

    $display("[TB] set beats clear, then reset mid-REQ with ack high");
    @(negedge clk);
    auto_ack = 0;
    g = grant_cnt + 1;
    applyStimulus(4'b1000, {$urandom(), $urandom(), $urandom(), $urandom()});
    waitGrant(g, 100, "rst_case_grant");
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) err_clr = 1'b1;
      #2;
      if (k == 15) checkOutput("setwin_before", timeout_err, 0);
      if (k == 16) checkOutput("setwin_set", timeout_err, 1);
    end
    @(negedge clk);
    err_clr = 1'b0;
    xfer_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    rr_model = 0;
    prev_grant = 0;
    aborted++;
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("rstmid_req", xfer_req, 0);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_tmo", timeout_err, 0);
    checkOutput("rstmid_ready", in_ready, 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #2;
      checkOutput("stale_ack_block", in_ready, 0);
    end
    @(negedge clk);
    xfer_ack = 1'b0;
    #2;
    checkOutput("ack_fall_c0", in_ready, 0);
    @(negedge clk);
    #2;
    checkOutput("ack_fall_c1", in_ready, 0);
    @(negedge clk);
    #2;
    checkOutput("ack_fall_c2", in_ready, 4'b1000);
    @(negedge clk);
    in_valid = '0;
    d = done_cnt + 1;
    ack_dly = 2;
    auto_ack = 1;
    waitDone(d, 100, "rstmid_done");

    $display("[TB] randomized ack delay");
    for (int it = 0; it < 12; it++) begin
      @(negedge clk);
      ack_dly = $urandom_range(0, 20);
      g = grant_cnt + 1;
      d = done_cnt + 1;
      applyStimulus(4'($urandom_range(1, 15)), {$urandom(), $urandom(), $urandom(), $urandom()});
      waitGrant(g, 200, "rand_grant");
      @(negedge clk);
      in_valid = '0;
      waitDone(d, 200, "rand_done");
    end
    @(negedge clk);
    #2;
    checkOutput("done_vs_ready", done_cnt, grant_cnt - aborted);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
